obj_telemetry_tx: RTL and testbench

- Return-path transmitter for the game-object location registers.
- Host debug link writes six 21-bit object locations into the fabric; this block reads them back to the host.
- On each trigger it snapshots all locations, frames them (sync, payload, checksum) and serialises the frame over a dedicated UART 8N1 line.
- Sits beside the display path and shares its object-location array and its periodic valid strobe.

---
 rtl/obj_telemetry_tx.sv | 183 ++++++++++++++++++
 tb/tb_obj_telemetry_tx.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/obj_telemetry_tx.sv
`default_nettype none
// ============================================================================
//  Module   : obj_telemetry_tx
//  Purpose  : Return-path telemetry transmitter. On each trigger it snapshots
//             all game-object locations, frames them as
//               SYNC_BYTE, NUM_OBJ x 3 payload bytes (MS byte first), checksum
//             and serialises the frame as UART 8N1 (LSB first, idle high).
//             The checksum is the modulo-256 sum of the payload bytes only.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_in          in   1                 system clock
//    rst_in          in   1                 synchronous reset, active low
//    valid_in        in   1                 one-cycle snapshot/send trigger
//    game_obj_loc    in   [OBJ_WIDTH-1:0] x NUM_OBJ, index 0 sent first
//    tx_out          out  1                 UART serial data, idle high
//    busy_out        out  1                 high while a frame is in flight
//    frame_done_out  out  1                 one-cycle pulse after last stop bit
//    drop_count_out  out  8                 saturating count of ignored triggers
// ============================================================================
module obj_telemetry_tx #(
  parameter int         CLKS_PER_BIT = 868,
  parameter int         NUM_OBJ      = 6,
  parameter int         OBJ_WIDTH    = 21,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 valid_in,
  input  logic [OBJ_WIDTH-1:0] game_obj_loc [NUM_OBJ],
  output logic                 tx_out,
  output logic                 busy_out,
  output logic                 frame_done_out,
  output logic [7:0]           drop_count_out
);

  // --------------------------------------------------------------------------
  // Derived sizes
  // --------------------------------------------------------------------------
  localparam int NUM_BYTES = NUM_OBJ * 3 + 2;
  localparam int LAST_BYTE = NUM_BYTES - 1;
  localparam int CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BYTE_W    = $clog2(NUM_BYTES);
  localparam int SNAP_W    = NUM_OBJ * 24;

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  // The "done" step of the frame is not a dwell state: the final STOP returns
  // straight to IDLE and raises frame_done_out, so a trigger arriving in the
  // frame_done_out cycle sees IDLE and is accepted.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CNT_W-1:0]  clk_cnt;    // cycles elapsed within the current bit
  logic [2:0]        bit_cnt;    // data bit index, LSB first
  logic [BYTE_W-1:0] byte_idx;   // byte index within the frame
  logic [7:0]        tx_byte;    // byte currently being serialised
  logic [7:0]        csum;       // running payload checksum
  logic [SNAP_W-1:0] snap_sr;    // snapshot, consumed 8 bits at a time
  logic [SNAP_W-1:0] live_flat;  // live inputs, zero-extended and packed

  logic bit_end;
  logic last_byte;

  // Object 0 occupies the most significant 24 bits so that shifting left
  // walks the payload in transmission order.
  for (genvar i = 0; i < NUM_OBJ; i++) begin : g_flat
    assign live_flat[(NUM_OBJ-1-i)*24 +: 24] = 24'(game_obj_loc[i]);
  end

  assign bit_end   = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign last_byte = (byte_idx == BYTE_W'(LAST_BYTE));

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tx_out    = 1'b1;
    busy_out  = 1'b1;
    case (state)
      IDLE: begin
        busy_out = 1'b0;
        if (valid_in) begin
          state_nxt = START;
        end
      end
      START: begin
        tx_out = 1'b0;
        if (bit_end) begin
          state_nxt = DATA;
        end
      end
      DATA: begin
        tx_out = tx_byte[bit_cnt];
        if (bit_end && (bit_cnt == 3'd7)) begin
          state_nxt = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_nxt = last_byte ? IDLE : START;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: counters, snapshot, byte selection, checksum, drop counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      clk_cnt        <= '0;
      bit_cnt        <= '0;
      byte_idx       <= '0;
      tx_byte        <= '0;
      csum           <= '0;
      snap_sr        <= '0;
      frame_done_out <= 1'b0;
      drop_count_out <= '0;
    end else begin
      frame_done_out <= 1'b0;

      if (valid_in && (state != IDLE) && (drop_count_out != 8'hFF)) begin
        drop_count_out <= drop_count_out + 8'd1;
      end

      if (state == IDLE) begin
        clk_cnt <= '0;
        bit_cnt <= '0;
        if (valid_in) begin
          snap_sr  <= live_flat;
          byte_idx <= '0;
          tx_byte  <= SYNC_BYTE;
          csum     <= '0;
        end
      end else begin
        clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;

        // bit_cnt wraps 7 -> 0 on the last data bit, ready for the next byte
        if ((state == DATA) && bit_end) begin
          bit_cnt <= bit_cnt + 3'd1;
        end

        // The next byte is loaded at the end of each stop bit. Payload bytes
        // are added to the checksum as they are loaded, so by the time the
        // checksum byte is due every payload byte has been summed.
        if ((state == STOP) && bit_end) begin
          if (last_byte) begin
            frame_done_out <= 1'b1;
          end else begin
            byte_idx <= byte_idx + 1'b1;
            if (byte_idx == BYTE_W'(LAST_BYTE - 1)) begin
              tx_byte <= csum;
            end else begin
              tx_byte <= snap_sr[SNAP_W-1 -: 8];
              csum    <= csum + snap_sr[SNAP_W-1 -: 8];
              snap_sr <= snap_sr << 8;
            end
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_obj_telemetry_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_obj_telemetry_tx
//  Purpose  : Self-checking bench for obj_telemetry_tx (CLKS_PER_BIT = 4).
//             Expected frame bytes are pushed to a scoreboard queue whenever
//             a trigger is accepted and popped as the captured serial line is
//             decoded.
//  Revision : 1.0  initial release
// ============================================================================
module tb_obj_telemetry_tx;

  localparam int CPB     = 4;
  localparam int NOBJ    = 6;
  localparam int NBYTES  = NOBJ * 3 + 2;
  localparam int FRAME_C = NBYTES * 10 * CPB;   // 800

  logic        clk;
  logic        rst;
  logic        valid;
  logic [20:0] loc [NOBJ];
  logic        tx;
  logic        busy;
  logic        done;
  logic [7:0]  drops;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] sq [$];

  logic tx_a   [0:1023];
  logic busy_a [0:1023];
  logic done_a [0:1023];

  obj_telemetry_tx #(
    .CLKS_PER_BIT (CPB),
    .NUM_OBJ      (NOBJ),
    .OBJ_WIDTH    (21),
    .SYNC_BYTE    (8'hA5)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .valid_in       (valid),
    .game_obj_loc   (loc),
    .tx_out         (tx),
    .busy_out       (busy),
    .frame_done_out (done),
    .drop_count_out (drops)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference frame built from the locations currently driven.
  function automatic void push_frame();
    logic [7:0]  s;
    logic [23:0] w;
    s = 8'h00;
    sq.push_back(8'hA5);
    for (int i = 0; i < NOBJ; i++) begin
      w = 24'(loc[i]);
      for (int b = 2; b >= 0; b--) begin
        sq.push_back(w[b*8 +: 8]);
        s = s + w[b*8 +: 8];
      end
    end
    sq.push_back(s);
  endfunction

  task automatic set_all(input logic [20:0] v);
    for (int i = 0; i < NOBJ; i++) loc[i] = v;
  endtask

  // Called at a negedge: raise valid, let edge k sample it, return at the
  // following negedge (sample index 0 = value registered at edge k).
  task automatic trigger();
    valid = 1'b1;
    push_frame();
    @(negedge clk);
  endtask

  // Records ncyc samples; sample j is the value registered at edge k+j.
  // After each sample the inputs for the next edge are driven.
  task automatic capture(input int ncyc, input int drop_from, input int drop_n,
                         input int chg_at, input logic [20:0] chg_val,
                         input int rst_at, input int retrig_at);
    for (int j = 0; j < ncyc; j++) begin
      tx_a[j]   = tx;
      busy_a[j] = busy;
      done_a[j] = done;
      valid = ((j >= drop_from) && (j < drop_from + drop_n)) || (j == retrig_at);
      if (j == chg_at) set_all(chg_val);
      if (j == rst_at) rst = 1'b0;
      if (j == retrig_at) push_frame();
      @(negedge clk);
    end
  endtask

  task automatic check_frame(input string tag);
    logic [9:0] got;
    logic [7:0] e;
    for (int b = 0; b < NBYTES; b++) begin
      for (int t = 0; t < 10; t++) got[t] = tx_a[b*40 + t*CPB + CPB/2];
      if (sq.size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL %s_sb_empty byte=%0d observed=%0h expected=none", tag, b, got);
      end else begin
        e = sq.pop_front();
        chk($sformatf("%s_byte%0d", tag, b), 32'(got), 32'({1'b1, e, 1'b0}));
      end
    end
  endtask

  task automatic check_timing(input string tag, input int ncyc);
    int fb;
    int nd;
    fb = -1;
    nd = 0;
    for (int j = 0; j < ncyc; j++) begin
      if (!busy_a[j] && fb < 0) fb = j;
      if (done_a[j]) nd++;
    end
    chk({tag, "_start_bit"}, 32'({tx_a[0], tx_a[1], tx_a[2], tx_a[3]}), 32'h0);
    chk({tag, "_busy_len"}, 32'(fb), 32'(FRAME_C));
    chk({tag, "_done_at"}, 32'(done_a[FRAME_C]), 32'h1);
    chk({tag, "_done_cnt"}, 32'(nd), 32'h1);
  endtask

  initial begin
    int lows;
    rst   = 1'b0;
    valid = 1'b1;
    set_all(21'h0);

    // Reset held with valid high: stays idle
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("rst_tx%0d", i), 32'(tx), 32'h1);
      chk($sformatf("rst_busy%0d", i), 32'(busy), 32'h0);
    end
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_drops", 32'(drops), 32'h0);
    rst   = 1'b1;
    valid = 1'b0;
    @(negedge clk);
    chk("rst_release_tx", 32'(tx), 32'h1);
    chk("rst_release_busy", 32'(busy), 32'h0);
    @(negedge clk);

    // Frame A: single object, 3 drops, inputs change after snapshot,
    // retrigger exactly in the frame_done cycle.
    loc[0] = 21'h12345;
    trigger();
    capture(FRAME_C + 1, 100, 3, 5, 21'h1FFFFF, -1, FRAME_C);
    check_timing("frA", FRAME_C + 1);
    check_frame("frA");
    chk("frA_drops", 32'(drops), 32'd3);

    // Frame B: all 1FFFFF (checksum wrap), inputs zeroed at k+10,
    // 300 drops saturate the counter.
    capture(FRAME_C + 2, 200, 300, 9, 21'h0, -1, -1);
    check_timing("frB", FRAME_C + 2);
    check_frame("frB");
    chk("frB_drops_sat", 32'(drops), 32'd255);

    // Frame C: reset during byte 5, bit 3
    for (int i = 0; i < NOBJ; i++) loc[i] = 21'(32'h0A1234 + i * 32'h1357);
    trigger();
    capture(5*40 + 3*CPB + 2, -1, 0, -1, 21'h0, 5*40 + 3*CPB, -1);
    chk("frC_pre_rst_busy", 32'(busy_a[5*40 + 3*CPB]), 32'h1);
    chk("frC_rst_tx", 32'(tx_a[5*40 + 3*CPB + 1]), 32'h1);
    chk("frC_rst_busy", 32'(busy_a[5*40 + 3*CPB + 1]), 32'h0);
    chk("frC_rst_drops", 32'(drops), 32'h0);
    sq.delete();
    rst = 1'b1;
    lows = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!tx || busy) lows++;
    end
    chk("frC_no_resume", 32'(lows), 32'h0);

    // Frame D: fresh frame after reset
    trigger();
    capture(FRAME_C + 2, -1, 0, -1, 21'h0, -1, -1);
    check_timing("frD", FRAME_C + 2);
    check_frame("frD");
    chk("frD_sb_left", 32'(sq.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
